// File: rtl/fetch_pkg.sv
// Shared definitions for the segmented core's instruction fetch stage.
//   NOP_INSTRUCTION : canonical RISC-V NOP (addi x0, x0, 0), loaded into IF/ID
//                     whenever the register holds a bubble.
//   INSTR_BYTES     : byte stride between sequential instructions.
//   if_id_t         : contents of the IF/ID pipeline register.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES     = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_pc_register.sv
// Program counter register with its next-PC selection.
// Ports:
//   clk             : core clock, rising edge
//   rst             : synchronous active-high reset, loads RESET_VECTOR
//   stall           : hold the PC
//   redirect        : load redirect_target (word aligned), wins over stall
//   redirect_target : new PC byte address; bits [1:0] are ignored
//   pc              : current fetch PC
module fetch_pc_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;

  // Misaligned targets are quietly forced onto a word boundary; there is no
  // trap path in this core. The +4 adder drops its carry, so the PC wraps.
  always_comb begin
    pc_next = pc_reg;
    if (redirect) begin
      pc_next = redirect_target & ~32'd3;
    end else if (!stall) begin
      pc_next = pc_reg + 32'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_VECTOR;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/instruction_fetch_unit_segmented.sv
// IF stage of the segmented RISC-V core. Holds the PC (via fetch_pc_register),
// drives the word address into the asynchronous instruction memory and
// captures the returned instruction into the IF/ID register.
// Ports:
//   clk, rst               : clock and synchronous active-high reset
//   stall                  : hold PC and IF/ID
//   redirect               : taken branch/jump; load redirect_target, bubble IF/ID
//   redirect_target        : new PC byte address
//   imem_address           : word address pc[memory_address_bits-1:2]
//   imem_data              : instruction read combinationally at imem_address
//   pc                     : current fetch PC
//   if_id_pc / if_id_instruction / if_id_valid : IF/ID register contents
// Optional build macro FETCH_PERF_COUNTERS_EN adds:
//   perf_fetched           : count of edges that loaded a valid instruction
//   perf_stall_cycles      : count of edges with stall=1 and redirect=0
module instruction_fetch_unit_segmented
  import fetch_pkg::*;
#(
  parameter int          memory_size         = 1024,
  parameter int          memory_address_bits = $clog2(memory_size),
  parameter logic [31:0] RESET_VECTOR        = 32'h0000_0000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             redirect,
  input  logic [31:0]                      redirect_target,
  output logic [memory_address_bits-3:0]   imem_address,
  input  logic [31:0]                      imem_data,
  output logic [31:0]                      pc,
  output logic [31:0]                      if_id_pc,
  output logic [31:0]                      if_id_instruction,
  output logic                             if_id_valid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]                      perf_fetched,
  output logic [31:0]                      perf_stall_cycles
`endif
);

  fetch_pc_register #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_register (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .pc             (pc)
  );

  // Truncation makes fetch wrap modulo memory_size.
  assign imem_address = pc[memory_address_bits-1:2];

  if_id_t if_id_reg;
  if_id_t if_id_next;

  always_comb begin
    if_id_next = if_id_reg;
    if (redirect) begin
      if_id_next = '{pc: 32'd0, instruction: NOP_INSTRUCTION, valid: 1'b0};
    end else if (!stall) begin
      if_id_next = '{pc: pc, instruction: imem_data, valid: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_reg <= '{pc: 32'd0, instruction: NOP_INSTRUCTION, valid: 1'b0};
    end else begin
      if_id_reg <= if_id_next;
    end
  end

  assign if_id_pc          = if_id_reg.pc;
  assign if_id_instruction = if_id_reg.instruction;
  assign if_id_valid       = if_id_reg.valid;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_stall_cycles_reg;

  // Both counters wrap naturally on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_reg      <= 32'd0;
      perf_stall_cycles_reg <= 32'd0;
    end else begin
      if (!redirect && !stall) begin
        perf_fetched_reg <= perf_fetched_reg + 32'd1;
      end
      if (!redirect && stall) begin
        perf_stall_cycles_reg <= perf_stall_cycles_reg + 32'd1;
      end
    end
  end

  assign perf_fetched      = perf_fetched_reg;
  assign perf_stall_cycles = perf_stall_cycles_reg;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit_segmented.sv
// Scoreboard bench for instruction_fetch_unit_segmented. The driver applies one
// directed vector per cycle and queues the hand-computed state expected after
// the next rising edge; a monitor pops and compares one entry per edge.
// Instruction memory model: word w holds 32'hAAAA_0000 + w + 1.
module tb_instruction_fetch_unit_segmented;

  localparam int MEM_SIZE = 1024;
  localparam int AW       = $clog2(MEM_SIZE);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_target = 32'd0;
  logic [AW-3:0] imem_address;
  logic [31:0]   imem_data;
  logic [31:0]   pc;
  logic [31:0]   if_id_pc;
  logic [31:0]   if_id_instruction;
  logic          if_id_valid;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_stall_cycles;
`endif

  instruction_fetch_unit_segmented #(
    .memory_size (MEM_SIZE),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .imem_address     (imem_address),
    .imem_data        (imem_data),
    .pc               (pc),
    .if_id_pc         (if_id_pc),
    .if_id_instruction(if_id_instruction),
    .if_id_valid      (if_id_valid)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .perf_fetched     (perf_fetched),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  assign imem_data = 32'hAAAA_0000 + {24'd0, imem_address} + 32'd1;

  typedef struct {
    int          row;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ins;
    logic        valid;
    logic [7:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   row_n = 0;

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL row%0d %s: got %h want %h", row, name, got, want);
    end
  endtask

  // Drive one vector ahead of the next rising edge and queue its expectation.
  task automatic vec(input logic r, input logic s, input logic d,
                     input logic [31:0] tgt, input logic [31:0] e_pc,
                     input logic [31:0] e_ifpc, input logic [31:0] e_ins,
                     input logic e_v, input logic [7:0] e_addr);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; redirect = d; redirect_target = tgt;
    e.row = row_n; e.pc = e_pc; e.ifpc = e_ifpc; e.ins = e_ins;
    e.valid = e_v; e.addr = e_addr;
    exp_q.push_back(e);
    $display("vec %0d: rst=%0b stall=%0b redirect=%0b target=%h -> pc=%h if_id_pc=%h ins=%h valid=%0b",
             row_n, r, s, d, tgt, e_pc, e_ifpc, e_ins, e_v);
    row_n++;
  endtask

  // Monitor: one comparison set per rising edge while expectations are pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",           e.row, pc,                     e.pc);
        chk("if_id_pc",     e.row, if_id_pc,               e.ifpc);
        chk("if_id_instr",  e.row, if_id_instruction,      e.ins);
        chk("if_id_valid",  e.row, {31'd0, if_id_valid},   {31'd0, e.valid});
        chk("imem_address", e.row, {24'd0, imem_address},  {24'd0, e.addr});
      end
    end
  end

  initial begin
    int waited;
    //  rst stall redir target         pc             if_id_pc       instr          v     addr
    vec(1, 0, 0, 32'h0,          32'h0000_0000, 32'h0,         32'h0000_0013, 1'b0, 8'd0);
    vec(0, 0, 0, 32'h0,          32'h0000_0004, 32'h0,         32'hAAAA_0001, 1'b1, 8'd1);
    vec(0, 0, 0, 32'h0,          32'h0000_0008, 32'h4,         32'hAAAA_0002, 1'b1, 8'd2);
    vec(0, 1, 0, 32'h0,          32'h0000_0008, 32'h4,         32'hAAAA_0002, 1'b1, 8'd2);
    vec(0, 1, 0, 32'h0,          32'h0000_0008, 32'h4,         32'hAAAA_0002, 1'b1, 8'd2);
    vec(0, 1, 0, 32'h0,          32'h0000_0008, 32'h4,         32'hAAAA_0002, 1'b1, 8'd2);
    vec(0, 0, 0, 32'h0,          32'h0000_000C, 32'h8,         32'hAAAA_0003, 1'b1, 8'd3);
    vec(0, 1, 1, 32'h40,         32'h0000_0040, 32'h0,         32'h0000_0013, 1'b0, 8'd16);
    vec(0, 0, 0, 32'h0,          32'h0000_0044, 32'h40,        32'hAAAA_0011, 1'b1, 8'd17);
    vec(0, 0, 1, 32'h43,         32'h0000_0040, 32'h0,         32'h0000_0013, 1'b0, 8'd16);
    vec(0, 0, 1, 32'h3F8,        32'h0000_03F8, 32'h0,         32'h0000_0013, 1'b0, 8'd254);
    vec(0, 0, 0, 32'h0,          32'h0000_03FC, 32'h3F8,       32'hAAAA_00FF, 1'b1, 8'd255);
    vec(0, 0, 0, 32'h0,          32'h0000_0400, 32'h3FC,       32'hAAAA_0100, 1'b1, 8'd0);
    vec(0, 0, 0, 32'h0,          32'h0000_0404, 32'h400,       32'hAAAA_0001, 1'b1, 8'd1);
    vec(0, 1, 0, 32'h0,          32'h0000_0404, 32'h400,       32'hAAAA_0001, 1'b1, 8'd1);
    vec(1, 1, 0, 32'h0,          32'h0000_0000, 32'h0,         32'h0000_0013, 1'b0, 8'd0);
    vec(1, 0, 1, 32'h80,         32'h0000_0000, 32'h0,         32'h0000_0013, 1'b0, 8'd0);
    vec(0, 0, 0, 32'h0,          32'h0000_0004, 32'h0,         32'hAAAA_0001, 1'b1, 8'd1);
    vec(0, 0, 1, 32'hFFFF_FFFE,  32'hFFFF_FFFC, 32'h0,         32'h0000_0013, 1'b0, 8'd255);
    vec(0, 0, 0, 32'h0,          32'h0000_0000, 32'hFFFF_FFFC, 32'hAAAA_0100, 1'b1, 8'd0);
    // Counter scenario: reset, 5 fetches, 2 stalls, 1 redirect.
    vec(1, 0, 0, 32'h0,          32'h0000_0000, 32'h0,         32'h0000_0013, 1'b0, 8'd0);
    vec(0, 0, 0, 32'h0,          32'h0000_0004, 32'h0,         32'hAAAA_0001, 1'b1, 8'd1);
    vec(0, 0, 0, 32'h0,          32'h0000_0008, 32'h4,         32'hAAAA_0002, 1'b1, 8'd2);
    vec(0, 0, 0, 32'h0,          32'h0000_000C, 32'h8,         32'hAAAA_0003, 1'b1, 8'd3);
    vec(0, 0, 0, 32'h0,          32'h0000_0010, 32'hC,         32'hAAAA_0004, 1'b1, 8'd4);
    vec(0, 0, 0, 32'h0,          32'h0000_0014, 32'h10,        32'hAAAA_0005, 1'b1, 8'd5);
    vec(0, 1, 0, 32'h0,          32'h0000_0014, 32'h10,        32'hAAAA_0005, 1'b1, 8'd5);
    vec(0, 1, 0, 32'h0,          32'h0000_0014, 32'h10,        32'hAAAA_0005, 1'b1, 8'd5);
    vec(0, 0, 1, 32'h80,         32'h0000_0080, 32'h0,         32'h0000_0013, 1'b0, 8'd32);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
`ifdef FETCH_PERF_COUNTERS_EN
    chk("perf_fetched",      row_n, perf_fetched,      32'd5);
    chk("perf_stall_cycles", row_n, perf_stall_cycles, 32'd2);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
